layer_out_serializer: RTL

Parallel-to-serial bridge between two fully connected layers. Captures the `numNeurons` activation outputs a layer produces in one lockstep pulse, then replays them as one contiguous `myinput`/`myinputValid` burst into every neuron of the next layer. A neuron's accumulator needs exactly `numWeight` back-to-back valid cycles, with a gap before the next burst, so this block owns burst contiguity and downstream pacing. Placed once per layer boundary in the network top.

---
 rtl/fnn_pkg.sv | 10 +
 rtl/layer_out_serializer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fnn_pkg.sv
// Shared types for the fully connected network datapath blocks.
package fnn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        WAIT_DS = 2'd2
    } ser_state_t;

endpackage

// File: rtl/layer_out_serializer.sv
// Captures one lockstep frame of layer activations and replays it as a single
// contiguous serial burst, paced by the consuming layer's outvalid.
module layer_out_serializer
    import fnn_pkg::*;
#(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [numNeurons*dataWidth-1:0]  in_data,
    input  logic [numNeurons-1:0]            in_valid,
    input  logic                             next_outvalid,
    output logic [dataWidth-1:0]             out_data,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             err_overflow,
    output logic                             err_skew
);

    localparam int SER_CNT_W = $clog2(numNeurons);
    localparam int VEC_W     = numNeurons * dataWidth;
    localparam logic [SER_CNT_W-1:0] LAST_IDX = SER_CNT_W'(numNeurons - 1);

    ser_state_t             state;
    ser_state_t             state_next;
    logic [VEC_W-1:0]       hold_data;
    logic                   hold_full;
    logic [VEC_W-1:0]       shift_data;
    logic [SER_CNT_W-1:0]   cnt;

    logic                   all_valid;
    logic                   skew;
    logic                   drain;
    logic                   capture;
    logic                   drop;
    logic                   hold_full_next;
    logic [VEC_W-1:0]       shift_next;
    logic [SER_CNT_W-1:0]   cnt_next;
    logic                   out_valid_next;
    logic [dataWidth-1:0]   out_data_next;
    logic                   busy_next;

    // Capture / drain handshake on the hold register
    always_comb begin
        all_valid = &in_valid;
        skew      = (|in_valid) & ~all_valid;
        drain     = (state == IDLE) & hold_full;
        capture   = all_valid & (~hold_full | drain);
        drop      = all_valid & hold_full & ~drain;
        if (capture) begin
            hold_full_next = 1'b1;
        end else if (drain) begin
            hold_full_next = 1'b0;
        end else begin
            hold_full_next = hold_full;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_next = STREAM;
                end else begin
                    state_next = IDLE;
                end
            end
            STREAM: begin
                if (cnt == LAST_IDX) begin
                    state_next = WAIT_DS;
                end else begin
                    state_next = STREAM;
                end
            end
            WAIT_DS: begin
                if (next_outvalid) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_DS;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: element 0 is presented straight from the hold register so
    // the burst starts the cycle after the drain; the rest come off the shifter
    always_comb begin
        out_data_next = {dataWidth{1'b0}};
        shift_next    = shift_data;
        cnt_next      = cnt;
        case (state)
            IDLE: begin
                if (drain) begin
                    out_data_next = hold_data[dataWidth-1:0];
                    shift_next    = hold_data >> dataWidth;
                    cnt_next      = {SER_CNT_W{1'b0}};
                end else begin
                    cnt_next      = {SER_CNT_W{1'b0}};
                end
            end
            STREAM: begin
                cnt_next   = cnt + SER_CNT_W'(1);
                shift_next = shift_data >> dataWidth;
                if (cnt != LAST_IDX) begin
                    out_data_next = shift_data[dataWidth-1:0];
                end else begin
                    out_data_next = {dataWidth{1'b0}};
                end
            end
            WAIT_DS: begin
                out_data_next = {dataWidth{1'b0}};
            end
            default: begin
                out_data_next = {dataWidth{1'b0}};
            end
        endcase
        out_valid_next = (state_next == STREAM);
        busy_next      = (state_next != IDLE) | hold_full_next;
    end

    // Datapath, registered outputs and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data    <= {VEC_W{1'b0}};
            hold_full    <= 1'b0;
            shift_data   <= {VEC_W{1'b0}};
            cnt          <= {SER_CNT_W{1'b0}};
            out_data     <= {dataWidth{1'b0}};
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            err_overflow <= 1'b0;
            err_skew     <= 1'b0;
        end else begin
            if (capture) begin
                hold_data <= in_data;
            end else begin
                hold_data <= hold_data;
            end
            hold_full    <= hold_full_next;
            shift_data   <= shift_next;
            cnt          <= cnt_next;
            out_data     <= out_data_next;
            out_valid    <= out_valid_next;
            busy         <= busy_next;
            err_overflow <= err_overflow | drop;
            err_skew     <= err_skew | skew;
        end
    end

endmodule
